// File: rtl/ad995x_update_sequencer_if.sv
// Control-side bundle between the frequency/amplitude logic and the DDS update sequencer.
// Latency: none; plain wires.
// Backpressure: update_req is ignored while busy is high; requests are not queued.
//
// Signals:
//   ftw/asf          per-channel tuning word / amplitude scale, channel n in slice n
//   vco_gain         FR1 VCO gain bit
//   clock_multiplier FR1 PLL multiplier
//   update_req       one-cycle request to start a sweep
//   force_all        sampled with update_req, rewrites every channel
//   busy/init_done   sequencer status
interface ad995x_update_sequencer_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH*32-1:0] ftw;
    logic [NUM_CH*10-1:0] asf;
    logic                 vco_gain;
    logic [4:0]           clock_multiplier;
    logic                 update_req;
    logic                 force_all;
    logic                 busy;
    logic                 init_done;

    modport master (
        output ftw, asf, vco_gain, clock_multiplier, update_req, force_all,
        input  busy, init_done
    );

    modport slave (
        input  ftw, asf, vco_gain, clock_multiplier, update_req, force_all,
        output busy, init_done
    );
endinterface

// File: rtl/ad995x_update_sequencer.sv
// AD9958/AD9959 update sequencer: reset/init of the DDS, then writes only changed channels over SPI.
// Latency: one idle cycle to scan, then three SPI frames per dirty channel, then an io_update pulse.
// Backpressure: busy is high during init and sweeps; update_req seen while busy is dropped.
//
// Ports:
//   clock_i, reset_i  system clock, asynchronous active-high reset
//   ctl               control bundle (slave side)
//   cs_o, sclk_o      SPI chip select (active low) and clock
//   sdio_o            SPI data; sdio_o[3] carries the most significant bit of each nibble in 4-lane mode
//   master_reset_o    DDS master reset
//   io_update_o       DDS register transfer strobe
module ad995x_update_sequencer #(
    parameter int NUM_CH    = 4,
    parameter int LANES     = 4,
    parameter int SCLK_HALF = 2,
    parameter int RST_CYC   = 16,
    parameter int IOU_CYC   = 4
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    ad995x_update_sequencer_if.slave    ctl,
    output logic                        cs_o,
    output logic                        sclk_o,
    output logic [3:0]                  sdio_o,
    output logic                        master_reset_o,
    output logic                        io_update_o
);
    localparam int         CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic       WIDE      = (LANES == 4);
    localparam logic [1:0] MODE      = WIDE ? 2'b11 : 2'b00;
    localparam logic [3:0] ALL_EN    = 4'((1 << NUM_CH) - 1);
    localparam logic [5:0] NCLK_CSR  = WIDE ? 6'd4  : 6'd16;
    localparam logic [5:0] NCLK_24   = WIDE ? 6'd8  : 6'd32;
    localparam logic [5:0] NCLK_FTW  = WIDE ? 6'd10 : 6'd40;
    localparam logic [15:0] RST_LAST  = 16'(RST_CYC - 1);
    localparam logic [15:0] IOU_LAST  = 16'(IOU_CYC - 1);
    localparam logic [15:0] HALF_LAST = 16'(SCLK_HALF - 1);
    localparam logic [15:0] GAP_LAST  = 16'(2 * SCLK_HALF - 1);

    typedef enum logic [3:0] {
        S_RST_HOLD, S_INIT_CSR, S_INIT_FR1, S_IDLE, S_SCAN,
        S_CSR, S_FTW, S_ACR, S_IOU_WAIT, S_IOU_PULSE
    } state_t;

    typedef enum logic [2:0] {F_IDLE, F_LOW, F_HIGH, F_TAIL, F_GAP} fph_t;

    state_t state_q, state_d, frm_nxt;
    fph_t   fph_q, fph_d;

    logic [15:0] cnt_q, cnt_d, hc_q, hc_d;
    logic        sent_q, sent_d, init_done_q, init_done_d;
    logic        mrst_q, mrst_d, iou_q, iou_d;
    logic        cs_q, cs_d, sclk_q, sclk_d, wide_q, wide_d;
    logic [3:0]  sdio_q, sdio_d;
    logic [39:0] sr_q, sr_d;
    logic [5:0]  bc_q, bc_d;

    logic [31:0] snap_ftw_q [NUM_CH];
    logic [9:0]  snap_asf_q [NUM_CH];
    logic [31:0] shad_ftw_q [NUM_CH];
    logic [9:0]  shad_asf_q [NUM_CH];
    logic [NUM_CH-1:0] dirty_q, dirty_d, dirty_new, cur_oh;
    logic [CH_W-1:0]   cur_ch;
    logic [3:0]        en4;
    logic              snap_en, shad_en, f_start, is_frm, frm_done, frm_wide;
    logic [39:0]       frm_dat;
    logic [5:0]        frm_nclk;

    // Frames are left-aligned in a 40-bit word; the top bits go out first.
    function automatic logic [3:0] lead(input logic [39:0] x, input logic w);
        return w ? x[39:36] : {3'b000, x[39]};
    endfunction

    function automatic logic [39:0] shl(input logic [39:0] x, input logic w);
        return w ? {x[35:0], 4'h0} : {x[38:0], 1'b0};
    endfunction

    // Sweep order is ascending: the lowest dirty channel is always the current one,
    // and its dirty bit clears once its ACR frame is out.
    always_comb begin
        cur_ch = '0;
        cur_oh = '0;
        for (int n = NUM_CH - 1; n >= 0; n--) begin
            if (dirty_q[n]) begin
                cur_ch    = CH_W'(n);
                cur_oh    = '0;
                cur_oh[n] = 1'b1;
            end
        end
        en4 = 4'(cur_oh);
    end

    always_comb begin
        dirty_new = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            dirty_new[n] = ctl.force_all
                        || (ctl.ftw[n*32 +: 32] != shad_ftw_q[n])
                        || (ctl.asf[n*10 +: 10] != shad_asf_q[n]);
        end
    end

    assign frm_done = (fph_q == F_TAIL) && (hc_q == HALF_LAST);

    // Main sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sent_d      = sent_q;
        dirty_d     = dirty_q;
        init_done_d = init_done_q;
        snap_en     = 1'b0;
        shad_en     = 1'b0;
        f_start     = 1'b0;
        is_frm      = 1'b0;
        frm_nxt     = state_q;
        frm_dat     = '0;
        frm_nclk    = NCLK_CSR;
        frm_wide    = WIDE;
        case (state_q)
            S_RST_HOLD: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = '0;
                    state_d = S_INIT_CSR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            // The part powers up in 1-bit mode, so the mode switch itself goes out serially.
            S_INIT_CSR: begin
                is_frm   = 1'b1;
                frm_dat  = {8'h00, ALL_EN, 1'b0, MODE, 1'b0, 24'h0};
                frm_nclk = 6'd16;
                frm_wide = 1'b0;
                frm_nxt  = S_INIT_FR1;
            end
            S_INIT_FR1: begin
                is_frm   = 1'b1;
                frm_dat  = {8'h01, ctl.vco_gain, ctl.clock_multiplier, 18'h0, 8'h0};
                frm_nclk = NCLK_24;
                frm_nxt  = S_IOU_WAIT;
            end
            S_IDLE: begin
                if (ctl.update_req) begin
                    snap_en = 1'b1;
                    dirty_d = dirty_new;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: state_d = (dirty_q != '0) ? S_CSR : S_IDLE;
            S_CSR: begin
                is_frm   = 1'b1;
                frm_dat  = {8'h00, en4, 1'b0, MODE, 1'b0, 24'h0};
                frm_nclk = NCLK_CSR;
                frm_nxt  = S_FTW;
            end
            S_FTW: begin
                is_frm   = 1'b1;
                frm_dat  = {8'h04, snap_ftw_q[cur_ch]};
                frm_nclk = NCLK_FTW;
                frm_nxt  = S_ACR;
            end
            S_ACR: begin
                is_frm   = 1'b1;
                frm_dat  = {8'h06, 11'h0, 1'b1, 2'b00, snap_asf_q[cur_ch], 8'h0};
                frm_nclk = NCLK_24;
                frm_nxt  = ((dirty_q & ~cur_oh) != '0) ? S_CSR : S_IOU_WAIT;
            end
            S_IOU_WAIT: begin
                if (cnt_q == IOU_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IOU_PULSE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_IOU_PULSE: begin
                if (cnt_q == IOU_LAST) begin
                    cnt_d       = '0;
                    init_done_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_RST_HOLD;
        endcase
        // Frame states launch one frame once the shifter is idle (inter-frame gap
        // included) and advance on its cs rise, which also starts the io_update wait.
        if (is_frm) begin
            if (!sent_q) begin
                if (fph_q == F_IDLE) begin
                    f_start = 1'b1;
                    sent_d  = 1'b1;
                end
            end else if (frm_done) begin
                sent_d  = 1'b0;
                cnt_d   = '0;
                state_d = frm_nxt;
                if (state_q == S_ACR) begin
                    shad_en = 1'b1;
                    dirty_d = dirty_q & ~cur_oh;
                end
            end
        end
        mrst_d = (state_d == S_RST_HOLD);
        iou_d  = (state_d == S_IOU_PULSE);
    end

    // SPI shifter: each phase lasts SCLK_HALF cycles; data moves on the sclk fall.
    always_comb begin
        fph_d  = fph_q;
        hc_d   = hc_q;
        sr_d   = sr_q;
        bc_d   = bc_q;
        cs_d   = cs_q;
        sclk_d = sclk_q;
        sdio_d = sdio_q;
        wide_d = wide_q;
        case (fph_q)
            F_IDLE: begin
                if (f_start) begin
                    cs_d   = 1'b0;
                    sdio_d = lead(frm_dat, frm_wide);
                    sr_d   = shl(frm_dat, frm_wide);
                    bc_d   = frm_nclk;
                    wide_d = frm_wide;
                    hc_d   = '0;
                    fph_d  = F_LOW;
                end
            end
            F_LOW: begin
                if (hc_q == HALF_LAST) begin
                    sclk_d = 1'b1;
                    hc_d   = '0;
                    fph_d  = F_HIGH;
                end else begin
                    hc_d = hc_q + 16'd1;
                end
            end
            F_HIGH: begin
                if (hc_q == HALF_LAST) begin
                    sclk_d = 1'b0;
                    hc_d   = '0;
                    bc_d   = bc_q - 6'd1;
                    if (bc_q == 6'd1) begin
                        sdio_d = '0;
                        fph_d  = F_TAIL;
                    end else begin
                        sdio_d = lead(sr_q, wide_q);
                        sr_d   = shl(sr_q, wide_q);
                        fph_d  = F_LOW;
                    end
                end else begin
                    hc_d = hc_q + 16'd1;
                end
            end
            F_TAIL: begin
                if (hc_q == HALF_LAST) begin
                    cs_d  = 1'b1;
                    hc_d  = '0;
                    fph_d = F_GAP;
                end else begin
                    hc_d = hc_q + 16'd1;
                end
            end
            F_GAP: begin
                if (hc_q == GAP_LAST) begin
                    hc_d  = '0;
                    fph_d = F_IDLE;
                end else begin
                    hc_d = hc_q + 16'd1;
                end
            end
            default: fph_d = F_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_RST_HOLD;
            cnt_q       <= '0;
            sent_q      <= 1'b0;
            init_done_q <= 1'b0;
            mrst_q      <= 1'b1;
            iou_q       <= 1'b0;
            fph_q       <= F_IDLE;
            hc_q        <= '0;
            sr_q        <= '0;
            bc_q        <= '0;
            cs_q        <= 1'b1;
            sclk_q      <= 1'b0;
            sdio_q      <= '0;
            wide_q      <= 1'b0;
            dirty_q     <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                snap_ftw_q[n] <= '0;
                snap_asf_q[n] <= '0;
                shad_ftw_q[n] <= '0;
                shad_asf_q[n] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sent_q      <= sent_d;
            init_done_q <= init_done_d;
            mrst_q      <= mrst_d;
            iou_q       <= iou_d;
            fph_q       <= fph_d;
            hc_q        <= hc_d;
            sr_q        <= sr_d;
            bc_q        <= bc_d;
            cs_q        <= cs_d;
            sclk_q      <= sclk_d;
            sdio_q      <= sdio_d;
            wide_q      <= wide_d;
            dirty_q     <= dirty_d;
            for (int n = 0; n < NUM_CH; n++) begin
                if (snap_en) begin
                    snap_ftw_q[n] <= ctl.ftw[n*32 +: 32];
                    snap_asf_q[n] <= ctl.asf[n*10 +: 10];
                end
            end
            if (shad_en) begin
                shad_ftw_q[cur_ch] <= snap_ftw_q[cur_ch];
                shad_asf_q[cur_ch] <= snap_asf_q[cur_ch];
            end
        end
    end

    assign cs_o           = cs_q;
    assign sclk_o         = sclk_q;
    assign sdio_o         = sdio_q;
    assign master_reset_o = mrst_q;
    assign io_update_o    = iou_q;
    assign ctl.busy       = (state_q != S_IDLE);
    assign ctl.init_done  = init_done_q;
endmodule

// File: tb/tb_ad995x_update_sequencer.sv
// Directed bench for the DDS update sequencer: init sequence, partial sweeps, force_all,
// mid-sweep input changes and reset during a frame. SPI frames are decoded by a
// negedge monitor and compared against hand-computed words.
module tb_ad995x_update_sequencer;
    localparam int NUM_CH = 4, LANES = 4, SCLK_HALF = 2, RST_CYC = 16, IOU_CYC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs, sclk, mrst, iou;
    logic [3:0] sdio;

    ad995x_update_sequencer_if #(.NUM_CH(NUM_CH)) ctl ();

    ad995x_update_sequencer #(
        .NUM_CH(NUM_CH), .LANES(LANES), .SCLK_HALF(SCLK_HALF),
        .RST_CYC(RST_CYC), .IOU_CYC(IOU_CYC)
    ) dut (
        .clock_i(clk), .reset_i(rst), .ctl(ctl),
        .cs_o(cs), .sclk_o(sclk), .sdio_o(sdio),
        .master_reset_o(mrst), .io_update_o(iou)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor state (written only by the monitor process).
    int          cyc = 0, csf_cnt = 0, iou_cnt = 0, iou_w = 0;
    int          cs_rise_cyc = -1000, iou_rise_cyc = 0, min_gap = 1000;
    int          ncl = 0;
    logic [63:0] acc1 = '0, acc4 = '0;
    logic        hi = 1'b0, cs_prev = 1'b1, sclk_prev = 1'b0, iou_prev = 1'b0;
    int          q_ncl[$];
    logic [63:0] q_v1[$], q_v4[$];
    logic        q_hi[$];

    always @(negedge clk) begin
        cyc++;
        if (!cs && cs_prev) begin
            csf_cnt++;
            if (cyc - cs_rise_cyc < min_gap) min_gap = cyc - cs_rise_cyc;
            acc1 = '0; acc4 = '0; ncl = 0; hi = 1'b0;
        end
        if (!cs && sclk && !sclk_prev) begin
            acc1 = {acc1[62:0], sdio[0]};
            acc4 = {acc4[59:0], sdio};
            ncl++;
            if (sdio[3:1] != 3'b000) hi = 1'b1;
        end
        if (cs && !cs_prev) begin
            q_ncl.push_back(ncl); q_v1.push_back(acc1); q_v4.push_back(acc4); q_hi.push_back(hi);
            cs_rise_cyc = cyc;
        end
        if (iou && !iou_prev) begin
            iou_cnt++;
            iou_rise_cyc = cyc;
            iou_w = 0;
        end
        if (iou) iou_w++;
        cs_prev = cs; sclk_prev = sclk; iou_prev = iou;
    end

    int rd = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_frame(input string tag, input int n, input logic wide, input logic [63:0] val);
        if (rd >= q_ncl.size()) return;
        check({tag, " sclk count"}, 64'(q_ncl[rd]), 64'(n));
        check({tag, " data"}, wide ? q_v4[rd] : q_v1[rd], val);
        if (!wide) check({tag, " upper lanes idle"}, 64'(q_hi[rd]), 64'd0);
        rd++;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (ctl.busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " returns idle"}, 64'(ctl.busy), 64'd0);
    endtask

    task automatic pulse_req(input logic fa);
        ctl.force_all  = fa;
        ctl.update_req = 1'b1;
        @(posedge clk); #1;
        ctl.update_req = 1'b0;
        ctl.force_all  = 1'b0;
    endtask

    task automatic check_iou(input string tag, input int base);
        check({tag, " io_update count"}, 64'(iou_cnt - base), 64'd1);
        check({tag, " io_update width"}, 64'(iou_w), 64'(IOU_CYC));
        check({tag, " io_update delay"}, 64'(iou_rise_cyc - cs_rise_cyc), 64'(IOU_CYC));
    endtask

    function automatic logic [63:0] acr(input logic [9:0] a);
        return 64'h0600_1000 | 64'(a);
    endfunction

    logic [31:0] ftw_m [NUM_CH];
    logic [9:0]  asf_m [NUM_CH];

    task automatic set_ch(input int n, input logic [31:0] f, input logic [9:0] a);
        ftw_m[n] = f;
        asf_m[n] = a;
        ctl.ftw[n*32 +: 32] = f;
        ctl.asf[n*10 +: 10] = a;
    endtask

    initial begin
        int base_iou, base_csf, n;
        ctl.ftw = '0; ctl.asf = '0;
        ctl.vco_gain = 1'b1; ctl.clock_multiplier = 5'd20;
        ctl.update_req = 1'b0; ctl.force_all = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin ftw_m[i] = '0; asf_m[i] = '0; end

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst cs", 64'(cs), 64'd1);
        check("rst sclk", 64'(sclk), 64'd0);
        check("rst sdio", 64'(sdio), 64'd0);
        check("rst master_reset", 64'(mrst), 64'd1);
        check("rst io_update", 64'(iou), 64'd0);
        check("rst busy", 64'(ctl.busy), 64'd1);
        check("rst init_done", 64'(ctl.init_done), 64'd0);

        // Init sequence
        rst = 1'b0;
        n = 0;
        while (mrst && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("master_reset width", 64'(n), 64'(RST_CYC));
        base_iou = iou_cnt;
        wait_idle("init", 2000);
        check("init frames", 64'(q_ncl.size() - rd), 64'd2);
        expect_frame("init CSR", 16, 1'b0, 64'h00F6);
        expect_frame("init FR1", 8, 1'b1, 64'h01D0_0000);
        check_iou("init", base_iou);
        check("init_done", 64'(ctl.init_done), 64'd1);

        // Single channel change
        set_ch(2, 32'h1234_5678, 10'h3FF);
        base_iou = iou_cnt;
        rd = q_ncl.size();
        pulse_req(1'b0);
        check("ch2 busy", 64'(ctl.busy), 64'd1);
        wait_idle("ch2", 2000);
        check("ch2 frames", 64'(q_ncl.size() - rd), 64'd3);
        expect_frame("ch2 CSR", 4, 1'b1, 64'h0046);
        expect_frame("ch2 CFTW0", 10, 1'b1, 64'h04_1234_5678);
        expect_frame("ch2 ACR", 8, 1'b1, acr(10'h3FF));
        check_iou("ch2", base_iou);

        // Unchanged inputs: nothing to send
        base_iou = iou_cnt;
        base_csf = csf_cnt;
        pulse_req(1'b0);
        n = 0;
        while (ctl.busy && n < 50) begin
            n++;
            @(posedge clk); #1;
        end
        check("clean busy cycles", 64'(n), 64'd1);
        repeat (20) @(posedge clk);
        #1;
        check("clean cs falls", 64'(csf_cnt - base_csf), 64'd0);
        check("clean io_update", 64'(iou_cnt - base_iou), 64'd0);

        // force_all: every channel, ascending
        base_iou = iou_cnt;
        rd = q_ncl.size();
        pulse_req(1'b1);
        wait_idle("force", 4000);
        check("force frames", 64'(q_ncl.size() - rd), 64'd12);
        for (int c = 0; c < NUM_CH; c++) begin
            expect_frame($sformatf("force ch%0d CSR", c), 4, 1'b1, 64'(((16 << c) | 6)));
            expect_frame($sformatf("force ch%0d CFTW0", c), 10, 1'b1, {24'h0, 8'h04, ftw_m[c]});
            expect_frame($sformatf("force ch%0d ACR", c), 8, 1'b1, acr(asf_m[c]));
        end
        check_iou("force", base_iou);
        check("inter-frame gap", 64'(min_gap >= 2 * SCLK_HALF), 64'd1);

        // Input change mid-sweep uses the snapshot; next sweep picks it up
        set_ch(1, 32'hAAAA_0001, 10'h000);
        set_ch(3, 32'h0000_0000, 10'h155);
        base_csf = csf_cnt;
        rd = q_ncl.size();
        pulse_req(1'b0);
        n = 0;
        while (csf_cnt == base_csf && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("mid sweep started", 64'(csf_cnt - base_csf), 64'd1);
        set_ch(1, 32'hBBBB_0002, 10'h000);
        wait_idle("mid", 2000);
        check("mid frames", 64'(q_ncl.size() - rd), 64'd6);
        expect_frame("mid ch1 CSR", 4, 1'b1, 64'h0026);
        expect_frame("mid ch1 CFTW0", 10, 1'b1, 64'h04_AAAA_0001);
        expect_frame("mid ch1 ACR", 8, 1'b1, acr(10'h000));
        expect_frame("mid ch3 CSR", 4, 1'b1, 64'h0086);
        expect_frame("mid ch3 CFTW0", 10, 1'b1, 64'h04_0000_0000);
        expect_frame("mid ch3 ACR", 8, 1'b1, acr(10'h155));
        base_iou = iou_cnt;
        pulse_req(1'b0);
        wait_idle("next", 2000);
        check("next frames", 64'(q_ncl.size() - rd), 64'd3);
        expect_frame("next ch1 CSR", 4, 1'b1, 64'h0026);
        expect_frame("next ch1 CFTW0", 10, 1'b1, 64'h04_BBBB_0002);
        expect_frame("next ch1 ACR", 8, 1'b1, acr(10'h000));
        check_iou("next", base_iou);

        // Reset in the middle of a CFTW0 frame
        set_ch(0, 32'h0F0F_0F0F, 10'h000);
        base_csf = csf_cnt;
        pulse_req(1'b0);
        n = 0;
        while (csf_cnt - base_csf < 2 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("ftw frame started", 64'(csf_cnt - base_csf), 64'd2);
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst cs", 64'(cs), 64'd1);
        check("midrst sclk", 64'(sclk), 64'd0);
        check("midrst sdio", 64'(sdio), 64'd0);
        check("midrst master_reset", 64'(mrst), 64'd1);
        check("midrst busy", 64'(ctl.busy), 64'd1);
        check("midrst init_done", 64'(ctl.init_done), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        rd = q_ncl.size();
        base_iou = iou_cnt;
        wait_idle("reinit", 2000);
        check("reinit frames", 64'(q_ncl.size() - rd), 64'd2);
        expect_frame("reinit CSR", 16, 1'b0, 64'h00F6);
        expect_frame("reinit FR1", 8, 1'b1, 64'h01D0_0000);
        check_iou("reinit", base_iou);
        check("reinit init_done", 64'(ctl.init_done), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ad995x_update_sequencer.md
Name: ad995x_update_sequencer

Overview:
- Parametrised successor of the two-channel AD9958 controller; drives AD9958/AD9959-class DDS parts with NUM_CH channels (1..4) over SPI.
- Built-in SPI shifter supports 1-bit or 4-bit serial mode; master-reset/init sequence is included.
- Writes only channels whose FTW or ASF changed since the last sweep, then pulses io_update once per sweep.
- Sits between the frequency/amplitude control logic and the DDS pins, replacing the core + SPI + config-register trio.

Parameters:
- NUM_CH, 4, channel count, 1..4.
- LANES, 4, SPI data lanes, 1 or 4.
- SCLK_HALF, 2, clock cycles per sclk half-period, ≥1.
- RST_CYC, 16, master_reset high time after reset release, in clock cycles.
- IOU_CYC, 4, io_update pulse width, in clock cycles.

Ports:
- clock, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- ftw, in, NUM_CH*32, per-channel FTW; ch n occupies [32n+31:32n].
- asf, in, NUM_CH*10, per-channel ASF; ch n occupies [10n+9:10n].
- vco_gain, in, 1, FR1 bit 23.
- clock_multiplier, in, 5, FR1 bits 22:18.
- update_req, in, 1, single-cycle pulse: start a sweep.
- force_all, in, 1, sampled with update_req: treat every channel as dirty.
- busy, out, 1, high from reset through init and during any sweep.
- init_done, out, 1, high once the init sequence completes.
- cs, out, 1, SPI chip select, active low.
- sclk, out, 1, SPI clock.
- sdio, out, 4, SPI data; only sdio[0] is used in 1-bit mode.
- master_reset, out, 1, DDS master reset.
- io_update, out, 1, DDS IO update pulse.

Behaviour:
- Reset values: cs=1, sclk=0, sdio=0, master_reset=1, io_update=0, busy=1, init_done=0, shadow registers=0, state=RST_HOLD.
- Frame format: cs falls, then an 8-bit instruction (bit7=0 write, [4:0]=address), then data, MSB first.
- Frame timing: sdio changes while sclk is low; sclk rises after SCLK_HALF cycles. In 4-lane mode sdio[3:0] carries 4 bits per sclk; in 1-lane mode only sdio[0] carries data and sdio[3:1]=0.
- Frame end: cs rises SCLK_HALF cycles after the last sclk fall. cs stays high for ≥2*SCLK_HALF cycles between frames. sclk idles low.
- Register CSR 0x00: 8 data bits, [7:4]=channel enables, [2:1]=mode (00 for 1-bit, 11 for 4-bit).
- Register FR1 0x01: 24 data bits, {vco_gain, clock_multiplier, 18'b0}.
- Register CFTW0 0x04: 32 data bits, the FTW.
- Register ACR 0x06: 24 data bits, bit12=1 (multiplier enable), [9:0]=ASF, all other bits 0.
- State RST_HOLD: master_reset=1 for RST_CYC cycles after reset deasserts.
- State INIT_CSR: CSR write in 1-bit mode regardless of LANES. Enables=all present channels, mode per LANES. All following frames use LANES.
- State INIT_FR1: FR1 write. Then io_update pulse, then init_done=1, then IDLE.
- State IDLE: busy=0. update_req starts a sweep.
  - Snapshot all ftw/asf into working registers.
  - dirty[n] = force_all OR (snapshot ≠ shadow of last value sent for ch n).
  - If no channel is dirty: no frames, no io_update; busy high for exactly 1 cycle, then return to IDLE.
- State SWEEP: channels visited in ascending order. Each dirty channel gets CSR (one-hot enable), then CFTW0, then ACR; its shadow updates when its ACR frame completes. Clean channels are skipped with zero frames.
- State IOU: IOU_CYC cycles after the last cs rise, io_update is high for IOU_CYC cycles. Then IDLE.
- update_req while busy is ignored (no queuing). Input changes after the snapshot are picked up by the next sweep.
- Reset mid-frame: all outputs return to reset values immediately (cs=1 asynchronously) and the full init sequence reruns.
- Frame lengths in 4-lane mode: CSR 4 sclk, FR1/ACR 8 sclk, CFTW0 10 sclk.
- Frame lengths in 1-lane mode: CSR 16 sclk, FR1/ACR 32 sclk, CFTW0 40 sclk.

Test Plan:
- Reset release, LANES=4, SCLK_HALF=2: master_reset high 16 cycles. CSR frame on sdio[0] = 0x00,0xF6 over 16 sclk. FR1 frame with vco_gain=1, mult=20 = 0x01,0xD0_00_00 over 8 sclk. One io_update pulse, then init_done=1, busy=0.
- After init, ch2 ftw=0x1234_5678, asf=0x3FF, update_req: exactly 3 frames. CSR 0x00,0x46; CFTW0 0x04,0x12345678; ACR 0x06,0x0013FF. Then one 4-cycle io_update.
- Repeat update_req with unchanged inputs: zero cs falls, no io_update, busy high exactly 1 cycle.
- force_all=1 with update_req, NUM_CH=4: 12 frames in order ch0..ch3, then a single io_update.
- Change ch1 ftw mid-sweep: the current sweep sends the old snapshot value; the next update_req sends only ch1.
- Assert reset during a CFTW0 frame: cs=1 and sclk=0 in the same cycle, master_reset=1, and init reruns with its CSR frame in 1-bit mode.
